// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - load/store front end that turns byte..double requests into aligned 64-bit lane-masked bus transfers
// Three-state handshake: IDLE accepts, REQ waits for transfer_busy to rise, WAIT waits for it to fall.
module memory_unit #(
  parameter int DATA_SIZE = 64,
  parameter int ADDR_SIZE = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [1:0]           size,
  input  logic                 unsigned_load,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 req_ready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 done,
  output logic                 misaligned,
  output logic [ADDR_SIZE-1:0] mem_address,
  output logic                 transfer_enable,
  output logic [7:0]           byte_write_enable,
  output logic [DATA_SIZE-1:0] write_data,
  input  logic [DATA_SIZE-1:0] read_data,
  input  logic                 transfer_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic                 done_q, done_d;
  logic                 mis_q, mis_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 te_q, te_d;
  logic [7:0]           bwe_q, bwe_d;
  logic [DATA_SIZE-1:0] wd_q, wd_d;
  logic [2:0]           lane_q, lane_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic                 write_q, write_d;

  logic accept;
  logic is_aligned;

  function automatic logic [7:0] base_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic aligned(input logic [1:0] sz, input logic [2:0] lo);
    case (sz)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (lo[0] == 1'b0);
      2'b10:   aligned = (lo[1:0] == 2'b00);
      default: aligned = (lo == 3'b000);
    endcase
  endfunction

  // raw is already shifted down so the addressed element sits in the low bits
  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'b00:   extend = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      2'b01:   extend = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   extend = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: extend = raw;
    endcase
  endfunction

  assign accept     = rd_req | wr_req;
  assign is_aligned = aligned(size, addr[2:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      te_q    <= 1'b0;
      bwe_q   <= 8'h00;
      wd_q    <= '0;
      lane_q  <= 3'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      te_q    <= te_d;
      bwe_q   <= bwe_d;
      wd_q    <= wd_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_aligned) state_d = S_REQ;
      S_REQ:   if (transfer_busy) state_d = S_WAIT;
      S_WAIT:  if (!transfer_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    addr_d  = addr_q;
    te_d    = te_q;
    bwe_d   = bwe_q;
    wd_d    = wd_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !is_aligned) begin
          mis_d = 1'b1;
        end else if (accept) begin
          addr_d  = {addr[ADDR_SIZE-1:3], 3'b000};
          lane_d  = addr[2:0];
          size_d  = size;
          uns_d   = unsigned_load;
          write_d = wr_req;
          // store wins when both requests are raised together
          if (wr_req) begin
            te_d  = 1'b0;
            bwe_d = base_mask(size) << addr[2:0];
            wd_d  = (wdata & size_mask(size)) << {addr[2:0], 3'b000};
          end else begin
            te_d  = 1'b1;
            bwe_d = 8'h00;
          end
        end
      end
      S_WAIT: begin
        if (!transfer_busy) begin
          te_d   = 1'b0;
          bwe_d  = 8'h00;
          done_d = 1'b1;
          if (!write_q) begin
            rdata_d = extend(read_data >> {lane_q, 3'b000}, size_q, uns_q);
          end
        end
      end
      default: ;
    endcase
  end

  assign req_ready         = (state_q == S_IDLE) && !reset;
  assign rdata             = rdata_q;
  assign done              = done_q;
  assign misaligned        = mis_q;
  assign mem_address       = addr_q;
  assign transfer_enable   = te_q;
  assign byte_write_enable = bwe_q;
  assign write_data        = wd_q;

endmodule

// File: doc/memory_unit.md
# memory_unit

Load/store front end between the processor datapath and `memory_controller`. Accepts one byte, half, word or doubleword load/store per request and checks natural alignment. Converts each request into an aligned 64-bit bus transfer with the correct byte lanes, then runs the `transfer_busy` handshake. Returns sign- or zero-extended load data with a one-cycle completion pulse.

## Interface
- `DATA_SIZE`, 64: bus and register data width; fixed at 64.
- `ADDR_SIZE`, 64: address width.
- `clock` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_req` in 1: load request, sampled only when `req_ready`=1.
- `wr_req` in 1: store request, sampled only when `req_ready`=1; wins over `rd_req` if both high.
- `size` in 2: 00 byte, 01 half, 10 word, 11 double.
- `unsigned_load` in 1: 1 = zero-extend, 0 = sign-extend.
- `addr` in ADDR_SIZE: byte address.
- `wdata` in 64: store data, right-aligned.
- `req_ready` out 1: unit idle; equals (state==IDLE && !reset).
- `rdata` out 64: extended load result, valid while `done`=1, held afterwards.
- `done` out 1: one-cycle completion pulse.
- `misaligned` out 1: one-cycle error pulse.
- `mem_address` out ADDR_SIZE: `addr` with bits [2:0] cleared.
- `transfer_enable` out 1: read strobe to the controller.
- `byte_write_enable` out 8: write lane mask; nonzero marks a write. `transfer_enable` stays 0 during writes.
- `write_data` out 64: lane-shifted store data.
- `read_data` in 64: controller read data.
- `transfer_busy` in 1: controller busy.

## Operation
- States:
  - IDLE: ready to accept.
  - REQ: strobes driven; waits for `transfer_busy`=1.
  - WAIT: waits for `transfer_busy`=0.
- IDLE, accept with request present and aligned:
  - Register `mem_address` and `lane`=`addr[2:0]`.
  - Register `size`, `unsigned_load` and direction.
  - Read: `transfer_enable`<=1.
  - Write: `byte_write_enable` <= base mask << lane (base masks 0x01, 0x03, 0x0F, 0xFF); `write_data` <= (`wdata` masked to size) << 8*lane.
  - Next state REQ.
- Alignment check: `addr[0]` must be 0 for half, `addr[1:0]`=0 for word, `addr[2:0]`=0 for double.
- Misaligned accept: `misaligned`<=1 for one cycle; no strobe asserted; state stays IDLE; `rdata` unchanged.
- REQ: `transfer_busy`=1 moves to WAIT. There is no timeout; the unit stays in REQ until busy rises.
- WAIT, `transfer_busy` sampled 0:
  - Clear all strobes.
  - Read: `rdata` <= extend((`read_data` >> 8*lane) truncated to size).
  - `done`<=1.
  - Next state IDLE.
- Strobes and `mem_address` are held constant from accept through the exit edge of WAIT.
- `write_data` is held for the same interval.

## Timing
- Reset state IDLE. On the reset edge, these outputs go to 0:
  - `rdata`, `done`, `misaligned`
  - `mem_address`, `transfer_enable`, `byte_write_enable`, `write_data`
- `req_ready` is 0 while `reset` is high and 1 the first cycle after.
- Strobes appear the cycle after the accept edge.
- `done` rises the cycle after `transfer_busy` is first sampled low in WAIT. `rdata` is valid in that same cycle.
- Latency = 1 (accept) + busy-rise delay + busy duration + 1.
- `done` coincides with IDLE, so `req_ready`=1 in that cycle. A request accepted in the `done` cycle is legal and starts immediately (back-to-back).
- Reset in REQ or WAIT: next edge returns to IDLE and clears strobes. No `done` is produced.
- `rd_req`/`wr_req` asserted while not ready are ignored; the requester holds them until `req_ready`.

## Test plan
- Reset:
  - Stimulus: hold `reset` 3 cycles.
  - Response: all outputs 0 and `req_ready`=0 during reset; `req_ready`=1 the next cycle.
- Signed and unsigned byte load:
  - Stimulus: `addr`=0x0100_0003, `size`=00; controller returns 0x0000_0000_8000_0000.
  - Response: `mem_address`=0x0100_0000; `rdata`=0xFFFF_FFFF_FFFF_FF80 with `unsigned_load`=0, 0x80 with `unsigned_load`=1.
- Half store:
  - Stimulus: `wdata`=0x1234_BEEF at `addr`=0x0100_0006.
  - Response: `byte_write_enable`=0xC0, `write_data`=0xBEEF_0000_0000_0000, `transfer_enable`=0 throughout.
- Misaligned word load:
  - Stimulus: `addr`=0x0100_0002, `size`=10.
  - Response: `misaligned` high exactly 1 cycle; no strobe ever asserted; `done` stays 0.
- Doubleword load with a slow target:
  - Stimulus: busy rises 2 cycles after the strobe and stays high 20 cycles.
  - Response: `transfer_enable` held continuously; `done` exactly 1 cycle after busy falls; `rdata` equals `read_data`.
- Reset mid-transfer:
  - Stimulus: assert `reset` during WAIT, then issue a new load after release.
  - Response: strobes drop on the next edge; no `done` for the aborted transfer; the new load completes normally.
